// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model: oversamples the SPI link in the clk domain, decodes 48-bit
// commands, answers R1/R3/R7 and serves CMD17 single-block reads with a counting pattern.
module sd_spi_card_responder #(
    parameter int          NCR_BYTES  = 1,
    parameter int          NAC_BYTES  = 4,
    parameter int          INIT_COUNT = 2,
    parameter logic [31:0] OCR_VALUE  = 32'hC0FF8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        card_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_NCR, S_RESP, S_NAC, S_TOKEN, S_DATA, S_CRC
    } state_t;

    localparam logic [12:0] NCR_LAST = 13'(NCR_BYTES * 8 - 1);
    localparam logic [12:0] NAC_LAST = 13'(NAC_BYTES * 8 - 1);

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    logic [1:0]  cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic        sclk_prev_q;
    logic        cs_s, mosi_s, sclk_rise, sclk_fall;

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic        prev_zero_q, prev_zero_d;
    logic        resp_long_q, resp_long_d;
    logic        rd_pend_q, rd_pend_d;
    logic        app_cmd_q, app_cmd_d;
    logic [7:0]  init_cnt_q, init_cnt_d;
    logic        ready_q, ready_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        valid_q, valid_d;
    logic        miso_q, miso_d;
    logic [37:0] shreg_q, shreg_d;
    logic [39:0] resp_q, resp_d;
    logic [15:0] crc_q, crc_d;

    logic        out_bit, ready_n, illegal, has_extra;
    logic [7:0]  acmd_cnt, data_byte;
    logic [31:0] extra;

    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;

    // Bit presented to the host for its next SCLK rising edge.
    always_comb begin
        data_byte = arg_q[7:0] + cnt_q[10:3];
        out_bit   = 1'b1;
        case (state_q)
            S_RESP:  out_bit = resp_q[39];
            S_TOKEN: out_bit = (cnt_q[2:0] != 3'd7);
            S_DATA:  out_bit = data_byte[3'd7 - cnt_q[2:0]];
            S_CRC:   out_bit = crc_q[15];
            default: out_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_zero_d = prev_zero_q;
        resp_long_d = resp_long_q;
        rd_pend_d   = rd_pend_q;
        app_cmd_d   = app_cmd_q;
        init_cnt_d  = init_cnt_q;
        ready_d     = ready_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        valid_d     = 1'b0;
        miso_d      = miso_q;
        shreg_d     = shreg_q;
        resp_d      = resp_q;
        crc_d       = crc_q;
        acmd_cnt    = init_cnt_q + 8'd1;
        ready_n     = ready_q;
        illegal     = 1'b0;
        has_extra   = 1'b0;
        extra       = 32'h0;

        if (cs_s) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            prev_zero_d = 1'b0;
            miso_d      = 1'b1;
        end else begin
            if (sclk_rise) begin
                cnt_d = cnt_q + 13'd1;
                case (state_q)
                    S_IDLE: begin
                        cnt_d       = '0;
                        prev_zero_d = ~mosi_s;
                        if (prev_zero_q && mosi_s) begin
                            state_d     = S_CMD;
                            cnt_d       = 13'd2;
                            prev_zero_d = 1'b0;
                        end
                    end
                    S_CMD: begin
                        // Only index and argument are kept; CRC7 and stop bit are clocked past.
                        if (cnt_q <= 13'd39) shreg_d = {shreg_q[36:0], mosi_s};
                        if (cnt_q == 13'd47) begin
                            idx_d     = shreg_q[37:32];
                            arg_d     = shreg_q[31:0];
                            valid_d   = 1'b1;
                            app_cmd_d = 1'b0;
                            rd_pend_d = 1'b0;
                            state_d   = S_NCR;
                            cnt_d     = '0;
                            case (shreg_q[37:32])
                                6'd0: begin
                                    init_cnt_d = '0;
                                    ready_n    = 1'b0;
                                end
                                6'd8: begin
                                    has_extra = 1'b1;
                                    extra     = {20'h0, shreg_q[11:0]};
                                end
                                6'd16: ;
                                6'd17: begin
                                    if (ready_q) rd_pend_d = 1'b1;
                                    else         illegal   = 1'b1;
                                end
                                6'd41: begin
                                    if (app_cmd_q) begin
                                        init_cnt_d = acmd_cnt;
                                        if (acmd_cnt == 8'(INIT_COUNT)) ready_n = 1'b1;
                                    end else begin
                                        illegal = 1'b1;
                                    end
                                end
                                6'd55: app_cmd_d = 1'b1;
                                6'd58: begin
                                    has_extra = 1'b1;
                                    extra     = OCR_VALUE;
                                end
                                default: illegal = 1'b1;
                            endcase
                            ready_d     = ready_n;
                            resp_d      = {5'b0, illegal, 1'b0, ~ready_n, extra};
                            resp_long_d = has_extra;
                        end
                    end
                    S_NCR: begin
                        if (cnt_q == NCR_LAST) begin
                            state_d = S_RESP;
                            cnt_d   = '0;
                        end
                    end
                    S_RESP: begin
                        resp_d = {resp_q[38:0], 1'b0};
                        if (cnt_q == (resp_long_q ? 13'd39 : 13'd7)) begin
                            state_d = rd_pend_q ? S_NAC : S_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    S_NAC: begin
                        if (cnt_q == NAC_LAST) begin
                            state_d = S_TOKEN;
                            cnt_d   = '0;
                        end
                    end
                    S_TOKEN: begin
                        if (cnt_q == 13'd7) begin
                            state_d = S_DATA;
                            cnt_d   = '0;
                            crc_d   = 16'h0000;
                        end
                    end
                    S_DATA: begin
                        crc_d = crc16_step(crc_q, out_bit);
                        if (cnt_q == 13'd4095) begin
                            state_d = S_CRC;
                            cnt_d   = '0;
                        end
                    end
                    S_CRC: begin
                        crc_d = {crc_q[14:0], 1'b0};
                        if (cnt_q == 13'd15) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            if (sclk_fall) miso_d = out_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= 2'b11;
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b11;
            sclk_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prev_zero_q <= 1'b0;
            resp_long_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            app_cmd_q   <= 1'b0;
            init_cnt_q  <= '0;
            ready_q     <= 1'b0;
            idx_q       <= '0;
            arg_q       <= '0;
            valid_q     <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi_cs};
            sclk_sync_q <= {sclk_sync_q[0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[1];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_zero_q <= prev_zero_d;
            resp_long_q <= resp_long_d;
            rd_pend_q   <= rd_pend_d;
            app_cmd_q   <= app_cmd_d;
            init_cnt_q  <= init_cnt_d;
            ready_q     <= ready_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            valid_q     <= valid_d;
            miso_q      <= miso_d;
        end
    end

    // Shift registers are always reloaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        resp_q  <= resp_d;
        crc_q   <= crc_d;
    end

    assign spi_miso   = miso_q;
    assign cmd_valid  = valid_q;
    assign cmd_index  = idx_q;
    assign cmd_arg    = arg_q;
    assign card_ready = ready_q;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder: drives SPI mode-0 frames at clk/8 and
// checks responses, the CMD17 data block and CRC, deselect abort and reset abort.
module tb_sd_spi_card_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs, spi_clk, spi_mosi;
    logic        spi_miso, cmd_valid, card_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;

    sd_spi_card_responder dut (
        .clk        (clk),
        .rst        (rst),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .cmd_valid  (cmd_valid),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .card_ready (card_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cmd_valid === 1'b1) vcnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #40 spi_clk = 1'b1;
            rx[i] = spi_miso;
            #40 spi_clk = 1'b0;
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] rx;
        xfer(8'hFF, rx);
        check(tag, {24'h0, rx}, {24'h0, exp});
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] rx;
        xfer(8'hFF, rx);
        xfer({2'b01, idx}, rx);
        xfer(arg[31:24], rx);
        xfer(arg[23:16], rx);
        xfer(arg[15:8], rx);
        xfer(arg[7:0], rx);
        xfer(crc, rx);
    endtask

    task automatic expect_read_head(input string tag);
        expect_byte({tag, "_ncr"}, 8'hFF);
        expect_byte({tag, "_r1"}, 8'h00);
        for (int i = 0; i < 4; i++) expect_byte({tag, "_nac"}, 8'hFF);
        expect_byte({tag, "_token"}, 8'hFE);
    endtask

    function automatic logic [15:0] crc_ref(input logic [7:0] first);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            b = first + 8'(i);
            c = c ^ {b, 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    initial begin
        logic [7:0]  rx;
        logic [15:0] crc_exp;
        int          fe_seen;

        rst = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b1;
        #22;
        check("rst_miso", {31'h0, spi_miso}, 32'h1);
        check("rst_valid", {31'h0, cmd_valid}, 32'h0);
        check("rst_index", {26'h0, cmd_index}, 32'h0);
        check("rst_arg", cmd_arg, 32'h0);
        check("rst_ready", {31'h0, card_ready}, 32'h0);
        rst = 1'b0;
        #40 spi_cs = 1'b0;
        #40;
        xfer(8'hFF, rx);
        xfer(8'hFF, rx);

        send_cmd(6'd0, 32'h0, 8'h95);
        expect_byte("cmd0_ncr", 8'hFF);
        expect_byte("cmd0_r1", 8'h01);
        check("cmd0_valid_cnt", vcnt, 1);
        check("cmd0_index", {26'h0, cmd_index}, 32'd0);
        check("cmd0_arg", cmd_arg, 32'h0);

        send_cmd(6'd8, 32'h000001AA, 8'h87);
        expect_byte("cmd8_ncr", 8'hFF);
        expect_byte("cmd8_r1", 8'h01);
        expect_byte("cmd8_b1", 8'h00);
        expect_byte("cmd8_b2", 8'h00);
        expect_byte("cmd8_b3", 8'h01);
        expect_byte("cmd8_b4", 8'hAA);
        check("cmd8_index", {26'h0, cmd_index}, 32'd8);
        check("cmd8_arg", cmd_arg, 32'h000001AA);

        send_cmd(6'd17, 32'h5, 8'hFF);
        expect_byte("cmd17_early_ncr", 8'hFF);
        expect_byte("cmd17_early_r1", 8'h05);
        fe_seen = 0;
        for (int i = 0; i < 16; i++) begin
            xfer(8'hFF, rx);
            if (rx == 8'hFE) fe_seen++;
        end
        check("cmd17_early_no_token", fe_seen, 0);

        send_cmd(6'd55, 32'h0, 8'hFF);
        expect_byte("cmd55a_ncr", 8'hFF);
        expect_byte("cmd55a_r1", 8'h01);
        send_cmd(6'd41, 32'h40000000, 8'hFF);
        expect_byte("acmd41a_ncr", 8'hFF);
        expect_byte("acmd41a_r1", 8'h01);
        check("ready_after_first", {31'h0, card_ready}, 32'h0);
        send_cmd(6'd55, 32'h0, 8'hFF);
        expect_byte("cmd55b_ncr", 8'hFF);
        expect_byte("cmd55b_r1", 8'h01);
        send_cmd(6'd41, 32'h40000000, 8'hFF);
        expect_byte("acmd41b_ncr", 8'hFF);
        expect_byte("acmd41b_r1", 8'h00);
        check("ready_after_second", {31'h0, card_ready}, 32'h1);

        send_cmd(6'd58, 32'h0, 8'hFF);
        expect_byte("cmd58_ncr", 8'hFF);
        expect_byte("cmd58_r1", 8'h00);
        expect_byte("cmd58_ocr3", 8'hC0);
        expect_byte("cmd58_ocr2", 8'hFF);
        expect_byte("cmd58_ocr1", 8'h80);
        expect_byte("cmd58_ocr0", 8'h00);

        send_cmd(6'd2, 32'h0, 8'hFF);
        expect_byte("cmd2_ncr", 8'hFF);
        expect_byte("cmd2_r1", 8'h04);

        send_cmd(6'd17, 32'h5, 8'hFF);
        expect_read_head("rd");
        for (int i = 0; i < 512; i++) begin
            xfer(8'hFF, rx);
            check($sformatf("rd_data%0d", i), {24'h0, rx}, {24'h0, 8'(5 + i)});
        end
        crc_exp = crc_ref(8'h05);
        expect_byte("rd_crc_hi", crc_exp[15:8]);
        expect_byte("rd_crc_lo", crc_exp[7:0]);

        send_cmd(6'd17, 32'h5, 8'hFF);
        expect_read_head("ab");
        for (int i = 0; i < 100; i++) xfer(8'hFF, rx);
        #30;
        check("abort_pre_miso", {31'h0, spi_miso}, 32'h0);
        spi_cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_miso_high", {31'h0, spi_miso}, 32'h1);
        check("abort_ready_kept", {31'h0, card_ready}, 32'h1);
        #6 spi_cs = 1'b0;
        #40;

        send_cmd(6'd17, 32'h10, 8'hFF);
        expect_read_head("re");
        expect_byte("re_data0", 8'h10);
        expect_byte("re_data1", 8'h11);
        expect_byte("re_data2", 8'h12);
        #30;
        check("rst_pre_miso", {31'h0, spi_miso}, 32'h0);
        rst = 1'b1;
        #1;
        check("midrst_miso", {31'h0, spi_miso}, 32'h1);
        check("midrst_ready", {31'h0, card_ready}, 32'h0);
        check("midrst_index", {26'h0, cmd_index}, 32'h0);
        check("midrst_arg", cmd_arg, 32'h0);
        #9 rst = 1'b0;
        #40;
        send_cmd(6'd17, 32'h5, 8'hFF);
        expect_byte("post_rst_ncr", 8'hFF);
        expect_byte("post_rst_r1", 8'h05);
        check("post_rst_index", {26'h0, cmd_index}, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
